// File: rtl/dcompressor_pkg.sv
// Shared constants, types and helpers for the envelope-driven dynamic range compressor.
package dcompressor_pkg;

    localparam int DCOMP_LATENCY = 3;

    // Direction the envelope follower moves for the current sample.
    typedef enum logic [1:0] {
        ENV_HOLD    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_RELEASE = 2'd2
    } env_dir_e;

    // Largest representable magnitude of a signed sample of the given width.
    function automatic int dcomp_mag_max(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/dcompressor_envelope.sv
// Attack/release envelope follower; advances only on valid magnitudes.
module dcompressor_envelope
    import dcompressor_pkg::*;
#(
    parameter int MAG_W         = 7,
    parameter int ATTACK_SHIFT  = 0,
    parameter int RELEASE_SHIFT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    input  logic [MAG_W-1:0] i_mag,
    output logic [MAG_W-1:0] o_env
);

    env_dir_e         dir;
    logic [MAG_W-1:0] rise;
    logic [MAG_W-1:0] fall;

    always_comb begin
        dir = ENV_HOLD;
        if (i_mag > o_env) begin
            dir = ENV_ATTACK;
        end else if (i_mag < o_env) begin
            dir = ENV_RELEASE;
        end
        rise = (i_mag - o_env) >> ATTACK_SHIFT;
        fall = (o_env - i_mag) >> RELEASE_SHIFT;
    end

    // Steps never overshoot the target magnitude, so no saturation is needed.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_env <= '0;
        end else if (i_valid) begin
            case (dir)
                ENV_ATTACK:  o_env <= o_env + rise;
                ENV_RELEASE: o_env <= o_env - fall;
                default:     o_env <= o_env;
            endcase
        end
    end

endmodule

// File: rtl/dcompressor_env.sv
// Three-stage envelope-driven compressor: magnitude, envelope, gain.
// Optional makeup gain is built when DCOMPRESSOR_MAKEUP_EN is defined.
module dcompressor_env
    import dcompressor_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int ATTACK_SHIFT  = 0,
    parameter int RELEASE_SHIFT = 4,
    parameter int RATIO_W       = 3,
    parameter int MAKEUP_SHIFT  = 0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-2:0] i_threshold,
    input  logic [RATIO_W-1:0] i_ratio,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_reducing
);

    localparam int MAG_W = DATA_W - 1;

    typedef logic [DATA_W-1:0] sample_t;
    typedef logic [MAG_W-1:0]  mag_t;

    localparam mag_t MAG_MAX = MAG_W'(dcomp_mag_max(DATA_W));

    if (DATA_W < 4 || MAKEUP_SHIFT < 0 || RATIO_W < 1) begin : g_param_check
        $error("dcompressor_env: unsupported parameter combination");
    end

    logic [DCOMP_LATENCY-1:0] valid_pipe;

    sample_t neg_data;
    mag_t    in_mag;
    mag_t    s1_mag;
    mag_t    s1_thr;
    logic    s1_neg;
    logic [RATIO_W-1:0] s1_ratio;

    mag_t    env;
    mag_t    s2_mag;
    mag_t    s2_thr;
    logic    s2_neg;
    logic [RATIO_W-1:0] s2_ratio;

    mag_t    excess;
    mag_t    reduction;
    mag_t    gain_mag;
    mag_t    final_mag;
    sample_t mag_ext;
    sample_t out_sample;

    // The most negative input has no positive twin, so it saturates.
    always_comb begin
        neg_data = -i_data;
        if (i_data[DATA_W-1]) begin
            in_mag = (i_data[DATA_W-2:0] == '0) ? MAG_MAX : neg_data[MAG_W-1:0];
        end else begin
            in_mag = i_data[MAG_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_pipe <= '0;
            s1_mag     <= '0;
            s1_thr     <= '0;
            s1_neg     <= 1'b0;
            s1_ratio   <= '0;
        end else begin
            valid_pipe <= {valid_pipe[DCOMP_LATENCY-2:0], i_valid};
            if (i_valid) begin
                s1_mag   <= in_mag;
                s1_thr   <= i_threshold;
                s1_neg   <= i_data[DATA_W-1];
                s1_ratio <= i_ratio;
            end
        end
    end

    dcompressor_envelope #(
        .MAG_W        (MAG_W),
        .ATTACK_SHIFT (ATTACK_SHIFT),
        .RELEASE_SHIFT(RELEASE_SHIFT)
    ) u_envelope (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_valid  (valid_pipe[0]),
        .i_mag    (s1_mag),
        .o_env    (env)
    );

    // Sample side-band travels with the envelope update so stage 3 sees matching data.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2_mag   <= '0;
            s2_thr   <= '0;
            s2_neg   <= 1'b0;
            s2_ratio <= '0;
        end else if (valid_pipe[0]) begin
            s2_mag   <= s1_mag;
            s2_thr   <= s1_thr;
            s2_neg   <= s1_neg;
            s2_ratio <= s1_ratio;
        end
    end

    // Shifting the excess by the ratio exponent leaves e/2^R; the rest is removed.
    always_comb begin
        excess    = (env > s2_thr) ? (env - s2_thr) : '0;
        reduction = excess - (excess >> s2_ratio);
        gain_mag  = (s2_mag > reduction) ? (s2_mag - reduction) : '0;
    end

`ifdef DCOMPRESSOR_MAKEUP_EN
    localparam int WIDE_W = MAG_W + MAKEUP_SHIFT + 1;

    logic [WIDE_W-1:0] boosted;

    always_comb begin
        boosted   = WIDE_W'(gain_mag) << MAKEUP_SHIFT;
        final_mag = (boosted > WIDE_W'(MAG_MAX)) ? MAG_MAX : boosted[MAG_W-1:0];
    end
`else
    assign final_mag = gain_mag;
`endif

    always_comb begin
        mag_ext    = {1'b0, final_mag};
        out_sample = s2_neg ? -mag_ext : mag_ext;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data     <= '0;
            o_reducing <= 1'b0;
        end else if (valid_pipe[1]) begin
            o_data     <= out_sample;
            o_reducing <= (reduction != '0);
        end
    end

    assign o_valid = valid_pipe[DCOMP_LATENCY-1];

endmodule

// File: tb/tb_dcompressor_env.sv
// Self-checking bench for dcompressor_env: directed scenarios plus randomized stream vs. a behavioural model.
module tb_dcompressor_env;

    localparam int DATA_W        = 8;
    localparam int ATTACK_SHIFT  = 0;
    localparam int RELEASE_SHIFT = 4;
    localparam int RATIO_W       = 3;
`ifdef DCOMPRESSOR_MAKEUP_EN
    localparam int MAKEUP_SHIFT  = 1;
`else
    localparam int MAKEUP_SHIFT  = 0;
`endif
    localparam int MAX_MAG = (1 << (DATA_W - 1)) - 1;

    logic               i_clk = 1'b0;
    logic               i_reset_n = 1'b0;
    logic               i_valid = 1'b0;
    logic [DATA_W-1:0]  i_data = '0;
    logic [DATA_W-2:0]  i_threshold = '0;
    logic [RATIO_W-1:0] i_ratio = '0;
    logic               o_valid;
    logic [DATA_W-1:0]  o_data;
    logic               o_reducing;

    int errors = 0;
    int checks = 0;
    int model_env = 0;

    typedef struct {
        bit v;
        int y;
        bit red;
    } exp_t;

    exp_t exp_q[$];

    dcompressor_env #(
        .DATA_W       (DATA_W),
        .ATTACK_SHIFT (ATTACK_SHIFT),
        .RELEASE_SHIFT(RELEASE_SHIFT),
        .RATIO_W      (RATIO_W),
        .MAKEUP_SHIFT (MAKEUP_SHIFT)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_threshold(i_threshold),
        .i_ratio    (i_ratio),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_reducing (o_reducing)
    );

    always #5 i_clk = ~i_clk;

    // Reference: compressor rules on plain integers, envelope kept as a running int.
    task automatic model_sample(input int x, input int t, input int r, output int y, output bit red_nz);
        int m, e, red, mag;
        m = (x < 0) ? -x : x;
        if (m > MAX_MAG) m = MAX_MAG;
        if (m > model_env) model_env = model_env + ((m - model_env) >> ATTACK_SHIFT);
        else if (m < model_env) model_env = model_env - ((model_env - m) >> RELEASE_SHIFT);
        e = (model_env > t) ? model_env - t : 0;
        red = e - (e >> r);
        mag = m - red;
        if (mag < 0) mag = 0;
`ifdef DCOMPRESSOR_MAKEUP_EN
        mag = mag << MAKEUP_SHIFT;
        if (mag > MAX_MAG) mag = MAX_MAG;
`endif
        y = (x < 0) ? -mag : mag;
        red_nz = (red != 0);
    endtask

    // Drives one cycle of input and returns the expectation for the output now visible.
    task automatic cycle(input bit v, input int x, input int t, input int r,
                         output bit ev, output int ey, output bit er);
        exp_t ent;
        i_valid     = v;
        i_data      = x[DATA_W-1:0];
        i_threshold = t[DATA_W-2:0];
        i_ratio     = r[RATIO_W-1:0];
        ent.v = v;
        ent.y = 0;
        ent.red = 1'b0;
        if (v) model_sample(x, t, r, ent.y, ent.red);
        exp_q.push_back(ent);
        @(negedge i_clk);
        ent = exp_q.pop_front();
        ev = ent.v;
        ey = ent.y;
        er = ent.red;
    endtask

    task automatic do_reset();
        exp_t idle;
        idle.v = 1'b0;
        idle.y = 0;
        idle.red = 1'b0;
        i_reset_n = 1'b0;
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        model_env = 0;
        exp_q.delete();
        repeat (2) exp_q.push_back(idle);
    endtask

    task automatic test_reset();
        bit ev, er;
        int ey;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_reducing !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_initial: got valid=%0b data=%0d red=%0b, expected all 0",
                     o_valid, $signed(o_data), o_reducing);
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, int'($urandom_range(0, 255)) - 128, 64, 2, ev, ey, er);
            checks++;
            if (o_valid !== 1'b0 || o_data !== '0 || o_reducing !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle[%0d]: got valid=%0b data=%0d red=%0b, expected all 0",
                         i, o_valid, $signed(o_data), o_reducing);
            end
        end
    endtask

    task automatic test_directed();
        int xs[8]    = '{50, 50, 50, 100, -100, 0, 70, -128};
        int lit_y[8] = '{50, 50, 50, 73, -73, 0, 48, -79};
        bit lit_r[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        int k = 0;
        bit ev, er;
        int ey;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (i < 8) cycle(1'b1, xs[i], 64, 2, ev, ey, er);
            else       cycle(1'b0, 0, 64, 2, ev, ey, er);
            checks++;
            if (o_valid !== ev) begin
                errors++;
                $display("[TB] FAIL directed_valid[%0d]: got %0b expected %0b", i, o_valid, ev);
            end
            if (ev) begin
                checks++;
                if (o_data !== ey[DATA_W-1:0] || o_reducing !== er) begin
                    errors++;
                    $display("[TB] FAIL directed_model[%0d]: got data=%0d red=%0b expected data=%0d red=%0b",
                             i, $signed(o_data), o_reducing, ey, er);
                end
`ifndef DCOMPRESSOR_MAKEUP_EN
                if (k < 8) begin
                    checks++;
                    if (int'($signed(o_data)) != lit_y[k] || o_reducing !== lit_r[k]) begin
                        errors++;
                        $display("[TB] FAIL directed_value[%0d]: got data=%0d red=%0b expected data=%0d red=%0b",
                                 k, $signed(o_data), o_reducing, lit_y[k], lit_r[k]);
                    end
                end
`endif
                k++;
            end
        end
    endtask

    task automatic test_gap();
        bit pat[8] = '{1, 0, 0, 1, 0, 0, 0, 0};
        bit ev, er;
        int ey;
`ifdef DCOMPRESSOR_MAKEUP_EN
        int lit = MAX_MAG;
`else
        int lit = 73;
`endif
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (pat[i]) cycle(1'b1, 100, 64, 2, ev, ey, er);
            else cycle(1'b0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 127)),
                       int'($urandom_range(0, 7)), ev, ey, er);
            checks++;
            if (o_valid !== ev) begin
                errors++;
                $display("[TB] FAIL gap_valid[%0d]: got %0b expected %0b", i, o_valid, ev);
            end
            if (ev) begin
                checks++;
                if (o_data !== ey[DATA_W-1:0] || int'($signed(o_data)) != lit || o_reducing !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL gap_data[%0d]: got data=%0d red=%0b expected data=%0d red=1",
                             i, $signed(o_data), o_reducing, lit);
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        bit ev, er;
        int ey;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 120 - i, 10, 1, ev, ey, er);
        end
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_reducing !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midstream_reset: got valid=%0b data=%0d red=%0b, expected all 0",
                     o_valid, $signed(o_data), o_reducing);
        end
        @(negedge i_clk);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) cycle(1'b1, 20, 0, 1, ev, ey, er);
            else        cycle(1'b0, 0, 0, 1, ev, ey, er);
            checks++;
            if (o_valid !== ev || (ev && (o_data !== ey[DATA_W-1:0] || o_reducing !== er))) begin
                errors++;
                $display("[TB] FAIL post_reset[%0d]: got valid=%0b data=%0d red=%0b expected valid=%0b data=%0d red=%0b",
                         i, o_valid, $signed(o_data), o_reducing, ev, ey, er);
            end
        end
    endtask

    task automatic test_random();
        bit ev, er, v;
        int ey, x, t, r;
        do_reset();
        for (int i = 0; i < 403; i++) begin
            v = (i < 400) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 15))
                0:       x = -128;
                1:       x = 127;
                2:       x = 0;
                default: x = int'($urandom_range(0, 255)) - 128;
            endcase
            t = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127));
            r = int'($urandom_range(0, 7));
            cycle(v, x, t, r, ev, ey, er);
            checks++;
            if (o_valid !== ev || (ev && (o_data !== ey[DATA_W-1:0] || o_reducing !== er))) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got valid=%0b data=%0d red=%0b expected valid=%0b data=%0d red=%0b",
                         i, o_valid, $signed(o_data), o_reducing, ev, ey, er);
            end
        end
    endtask

    initial begin
        $display("[TB] dcompressor_env bench start");
        test_reset();
        test_directed();
        test_gap();
        test_midstream_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
